// File: rtl/bias_loader_pkg.sv
// bias_loader_pkg: shared FSM/mode types and the load-instruction field layout
// used by the multi-bank bias loader and its bank address generator.
package bias_loader_pkg;

    localparam int FIELD_W        = 16;
    localparam int MODE_W         = 2;
    localparam int BANK_SEL_W     = 4;
    localparam int BUF_START_LSB  = 32;
    localparam int WORD_CNT_LSB   = 48;
    localparam int DRAM_START_LSB = 64;
    localparam int BYTE_LEN_LSB   = 80;
    localparam int MODE_LSB       = 96;
    localparam int BANK_SEL_LSB   = 100;
    localparam int INST_USED_W    = BANK_SEL_LSB + BANK_SEL_W;

    typedef enum logic [2:0] {
        IDLE,
        ISSUE,
        STREAM,
        DRAIN,
        DONE
    } state_t;

    typedef enum logic [1:0] {
        MODE_SINGLE = 2'd0,
        MODE_BCAST  = 2'd1,
        MODE_STRIPE = 2'd2,
        MODE_RSVD   = 2'd3
    } mode_t;

    typedef struct packed {
        logic [BANK_SEL_W-1:0] bank_sel;
        mode_t                 mode;
        logic [FIELD_W-1:0]    byte_len;
        logic [FIELD_W-1:0]    dram_start;
        logic [FIELD_W-1:0]    word_cnt;
        logic [FIELD_W-1:0]    buf_start;
    } load_inst_t;

endpackage

// File: rtl/bias_bank_addr_gen.sv
// bias_bank_addr_gen: maps a word index and load mode to the destination bank
// mask and the shared bank write address (wrapping modulo the bank depth).
module bias_bank_addr_gen
    import bias_loader_pkg::*;
#(
    parameter int N_BANKS = 4,
    parameter int BUF_AW  = 9
) (
    input  logic [FIELD_W-1:0]    word_idx,
    input  mode_t                 mode,
    input  logic [BANK_SEL_W-1:0] bank_sel,
    input  logic [FIELD_W-1:0]    buf_start,
    output logic [N_BANKS-1:0]    bank_mask,
    output logic [BUF_AW-1:0]     addr
);

    localparam int                 BANK_SHIFT    = $clog2(N_BANKS);
    localparam logic [FIELD_W-1:0] BANK_IDX_MASK = FIELD_W'(N_BANKS - 1);

    logic [FIELD_W-1:0] stripe_bank;
    logic [FIELD_W-1:0] stripe_row;
    logic [FIELD_W-1:0] single_bank;

    // Reserved mode falls through to broadcast.
    always_comb begin
        stripe_bank = word_idx & BANK_IDX_MASK;
        stripe_row  = word_idx >> BANK_SHIFT;
        single_bank = FIELD_W'(bank_sel) & BANK_IDX_MASK;
        bank_mask   = '0;
        addr        = '0;
        case (mode)
            MODE_SINGLE: begin
                bank_mask = N_BANKS'(1) << single_bank;
                addr      = BUF_AW'(buf_start) + BUF_AW'(word_idx);
            end
            MODE_STRIPE: begin
                bank_mask = N_BANKS'(1) << stripe_bank;
                addr      = BUF_AW'(buf_start) + BUF_AW'(stripe_row);
            end
            default: begin
                bank_mask = '1;
                addr      = BUF_AW'(buf_start) + BUF_AW'(word_idx);
            end
        endcase
    end

endmodule

// File: rtl/bias_loader_mb.sv
// bias_loader_mb: decodes one load instruction, issues a single DRAM read and
// scatters the returned AXIS beats into N_BANKS buffer banks.
module bias_loader_mb
    import bias_loader_pkg::*;
#(
    parameter int  INST_W    = 128,
    parameter int  ADDR_W    = 64,
    parameter int  DATA_W    = 512,
    parameter int  XFER_W    = 32,
    parameter int  N_BANKS   = 4,
    parameter int  BUF_DEPTH = 512,
    localparam int BUF_AW    = $clog2(BUF_DEPTH)
) (
    input  logic              kernel_clk,
    input  logic              kernel_rst,
    input  logic              ap_start,
    output logic              ap_ready,
    output logic              ap_done,
    input  logic [ADDR_W-1:0] ctrl_addr_offset,
    input  logic [INST_W-1:0] ctrl_instruction,
    output logic              rd_start,
    output logic [ADDR_W-1:0] rd_addr,
    output logic [XFER_W-1:0] rd_size,
    input  logic              rd_done,
    input  logic              s_tvalid,
    output logic              s_tready,
    input  logic              s_tlast,
    input  logic [DATA_W-1:0] s_tdata,
    output logic [N_BANKS-1:0] buf_wr_valid,
    output logic [BUF_AW-1:0] buf_wr_addr,
    output logic [DATA_W-1:0] buf_wr_data,
    output logic              err_short
);

    state_t             state_q, state_d;
    load_inst_t         inst_q;
    logic [ADDR_W-1:0]  offset_q;
    logic [FIELD_W-1:0] word_idx_q;
    logic               rd_done_seen_q;
    logic               accept;
    logic               beat;
    logic               last_useful;
    logic               short_last;
    logic [N_BANKS-1:0] bank_mask;
    logic [BUF_AW-1:0]  bank_addr;
    logic               unused_inst_bits;

    assign unused_inst_bits = ^{ctrl_instruction[INST_W-1:INST_USED_W],
                                ctrl_instruction[BANK_SEL_LSB-1:MODE_LSB+MODE_W],
                                ctrl_instruction[BUF_START_LSB-1:0]};

    assign accept      = (state_q == IDLE) && ap_start;
    assign beat        = (state_q == STREAM) && s_tvalid;
    assign last_useful = (word_idx_q == inst_q.word_cnt - FIELD_W'(1));
    assign short_last  = s_tlast && !last_useful;

    // Read request stays stable from ISSUE until the next instruction is latched.
    assign rd_addr = offset_q + ADDR_W'(inst_q.dram_start);
    assign rd_size = XFER_W'(inst_q.byte_len);

    bias_bank_addr_gen #(
        .N_BANKS (N_BANKS),
        .BUF_AW  (BUF_AW)
    ) u_addr_gen (
        .word_idx  (word_idx_q),
        .mode      (inst_q.mode),
        .bank_sel  (inst_q.bank_sel),
        .buf_start (inst_q.buf_start),
        .bank_mask (bank_mask),
        .addr      (bank_addr)
    );

    always_ff @(posedge kernel_clk or posedge kernel_rst) begin
        if (kernel_rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        ap_ready = 1'b0;
        ap_done  = 1'b0;
        rd_start = 1'b0;
        s_tready = 1'b0;
        case (state_q)
            IDLE: begin
                ap_ready = 1'b1;
                if (ap_start) state_d = ISSUE;
            end
            ISSUE: begin
                if (inst_q.word_cnt == '0) begin
                    state_d = DONE;
                end else begin
                    rd_start = 1'b1;
                    state_d  = STREAM;
                end
            end
            STREAM: begin
                s_tready = 1'b1;
                if (beat && (last_useful || s_tlast)) state_d = DRAIN;
            end
            DRAIN: begin
                s_tready = 1'b1;
                if (rd_done || rd_done_seen_q) state_d = DONE;
            end
            DONE: begin
                ap_done = 1'b1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // rd_done may arrive before DRAIN, so it is remembered from ISSUE onwards.
    always_ff @(posedge kernel_clk or posedge kernel_rst) begin
        if (kernel_rst) begin
            inst_q         <= '0;
            offset_q       <= '0;
            word_idx_q     <= '0;
            rd_done_seen_q <= 1'b0;
        end else if (accept) begin
            inst_q.buf_start  <= ctrl_instruction[BUF_START_LSB +: FIELD_W];
            inst_q.word_cnt   <= ctrl_instruction[WORD_CNT_LSB +: FIELD_W];
            inst_q.dram_start <= ctrl_instruction[DRAM_START_LSB +: FIELD_W];
            inst_q.byte_len   <= ctrl_instruction[BYTE_LEN_LSB +: FIELD_W];
            inst_q.mode       <= mode_t'(ctrl_instruction[MODE_LSB +: MODE_W]);
            inst_q.bank_sel   <= ctrl_instruction[BANK_SEL_LSB +: BANK_SEL_W];
            offset_q          <= ctrl_addr_offset;
            word_idx_q        <= '0;
            rd_done_seen_q    <= 1'b0;
        end else begin
            if (beat) word_idx_q <= word_idx_q + FIELD_W'(1);
            if (rd_done && (state_q != IDLE)) rd_done_seen_q <= 1'b1;
        end
    end

    // Write port is one register stage behind the accepted beat.
    always_ff @(posedge kernel_clk or posedge kernel_rst) begin
        if (kernel_rst) begin
            buf_wr_valid <= '0;
            buf_wr_addr  <= '0;
            buf_wr_data  <= '0;
            err_short    <= 1'b0;
        end else begin
            buf_wr_valid <= beat ? bank_mask : '0;
            err_short    <= beat && short_last;
            if (beat) begin
                buf_wr_addr <= bank_addr;
                buf_wr_data <= s_tdata;
            end
        end
    end

endmodule

// File: tb/tb_bias_loader_mb.sv
// tb_bias_loader_mb: table-driven load vectors plus hand-written reset, zero-length
// and mid-stream reset sequences for the multi-bank bias loader.
module tb_bias_loader_mb;

    localparam int INST_W  = 128;
    localparam int ADDR_W  = 64;
    localparam int DATA_W  = 512;
    localparam int XFER_W  = 32;
    localparam int N_BANKS = 4;
    localparam int BUF_AW  = 9;

    logic              kernel_clk;
    logic              kernel_rst;
    logic              ap_start;
    logic              ap_ready;
    logic              ap_done;
    logic [ADDR_W-1:0] ctrl_addr_offset;
    logic [INST_W-1:0] ctrl_instruction;
    logic              rd_start;
    logic [ADDR_W-1:0] rd_addr;
    logic [XFER_W-1:0] rd_size;
    logic              rd_done;
    logic              s_tvalid;
    logic              s_tready;
    logic              s_tlast;
    logic [DATA_W-1:0] s_tdata;
    logic [N_BANKS-1:0] buf_wr_valid;
    logic [BUF_AW-1:0] buf_wr_addr;
    logic [DATA_W-1:0] buf_wr_data;
    logic              err_short;

    int n_compared = 0;
    int n_mismatch = 0;

    int ap_done_cnt  = 0;
    int rd_start_cnt = 0;
    int err_cnt      = 0;
    logic [N_BANKS-1:0] wr_mask_q[$];
    logic [BUF_AW-1:0]  wr_addr_q[$];
    logic [DATA_W-1:0]  wr_data_q[$];

    typedef struct {
        int          mode;
        int          bank_sel;
        int          buf_start;
        int          word_cnt;
        int          dram_start;
        int          byte_len;
        logic [63:0] offset;
        logic [63:0] exp_rd_addr;
        int          n_beats;
        int          tlast_at;
        bit          gaps;
        bit          rd_with_last;
        bit          poke_start;
        int          exp_writes;
        int          exp_short;
        int          exp_mask[8];
        int          exp_addr[8];
    } vec_t;

    vec_t tbl[9];

    bias_loader_mb #(
        .INST_W    (INST_W),
        .ADDR_W    (ADDR_W),
        .DATA_W    (DATA_W),
        .XFER_W    (XFER_W),
        .N_BANKS   (N_BANKS),
        .BUF_DEPTH (512)
    ) dut (
        .kernel_clk       (kernel_clk),
        .kernel_rst       (kernel_rst),
        .ap_start         (ap_start),
        .ap_ready         (ap_ready),
        .ap_done          (ap_done),
        .ctrl_addr_offset (ctrl_addr_offset),
        .ctrl_instruction (ctrl_instruction),
        .rd_start         (rd_start),
        .rd_addr          (rd_addr),
        .rd_size          (rd_size),
        .rd_done          (rd_done),
        .s_tvalid         (s_tvalid),
        .s_tready         (s_tready),
        .s_tlast          (s_tlast),
        .s_tdata          (s_tdata),
        .buf_wr_valid     (buf_wr_valid),
        .buf_wr_addr      (buf_wr_addr),
        .buf_wr_data      (buf_wr_data),
        .err_short        (err_short)
    );

    initial begin
        kernel_clk = 1'b0;
        forever #5 kernel_clk = ~kernel_clk;
    end

    always @(negedge kernel_clk) begin
        if (buf_wr_valid != '0) begin
            wr_mask_q.push_back(buf_wr_valid);
            wr_addr_q.push_back(buf_wr_addr);
            wr_data_q.push_back(buf_wr_data);
        end
        if (ap_done)   ap_done_cnt++;
        if (rd_start)  rd_start_cnt++;
        if (err_short) err_cnt++;
    end

    initial begin
        #2_000_000;
        $display("[TB] FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    function automatic logic [INST_W-1:0] mk_inst(input int mode, input int bank_sel,
            input int buf_start, input int word_cnt, input int dram_start, input int byte_len);
        logic [INST_W-1:0] r;
        r          = '0;
        r[47:32]   = 16'(buf_start);
        r[63:48]   = 16'(word_cnt);
        r[79:64]   = 16'(dram_start);
        r[95:80]   = 16'(byte_len);
        r[97:96]   = 2'(mode);
        r[103:100] = 4'(bank_sel);
        r[127:120] = 8'hEE;
        r[7:0]     = 8'h5A;
        return r;
    endfunction

    function automatic logic [DATA_W-1:0] mk_data(input int vidx, input int k);
        logic [31:0] w;
        w = 32'hA5A5_0000 ^ 32'(vidx * 256 + k);
        return {16{w}};
    endfunction

    function automatic vec_t makeVec(input int mode, input int bank_sel, input int buf_start,
            input int word_cnt, input int dram_start, input int byte_len,
            input logic [63:0] offset, input logic [63:0] exp_rd_addr,
            input int n_beats, input int tlast_at, input bit gaps, input bit rd_with_last,
            input bit poke_start, input int exp_writes, input int exp_short);
        vec_t v;
        v.mode         = mode;
        v.bank_sel     = bank_sel;
        v.buf_start    = buf_start;
        v.word_cnt     = word_cnt;
        v.dram_start   = dram_start;
        v.byte_len     = byte_len;
        v.offset       = offset;
        v.exp_rd_addr  = exp_rd_addr;
        v.n_beats      = n_beats;
        v.tlast_at     = tlast_at;
        v.gaps         = gaps;
        v.rd_with_last = rd_with_last;
        v.poke_start   = poke_start;
        v.exp_writes   = exp_writes;
        v.exp_short    = exp_short;
        v.exp_mask     = '{0, 0, 0, 0, 0, 0, 0, 0};
        v.exp_addr     = '{0, 0, 0, 0, 0, 0, 0, 0};
        return v;
    endfunction

    task automatic checkOutput(input string name, input logic [DATA_W-1:0] actual,
                               input logic [DATA_W-1:0] expected);
        n_compared++;
        if (actual !== expected) begin
            n_mismatch++;
            $display("[TB] FAIL %s: got %0h, expected %0h", name, actual, expected);
        end
    endtask

    task automatic applyStimulus(input vec_t v);
        ctrl_instruction = mk_inst(v.mode, v.bank_sel, v.buf_start, v.word_cnt,
                                   v.dram_start, v.byte_len);
        ctrl_addr_offset = v.offset;
        ap_start         = 1'b1;
        @(negedge kernel_clk);
        ap_start = 1'b0;
    endtask

    task automatic checkIdleOutputs(input string tag);
        checkOutput({tag, " ap_ready"},     ap_ready, 1);
        checkOutput({tag, " ap_done"},      ap_done, 0);
        checkOutput({tag, " rd_start"},     rd_start, 0);
        checkOutput({tag, " s_tready"},     s_tready, 0);
        checkOutput({tag, " buf_wr_valid"}, buf_wr_valid, 0);
        checkOutput({tag, " buf_wr_addr"},  buf_wr_addr, 0);
        checkOutput({tag, " buf_wr_data"},  buf_wr_data, 0);
        checkOutput({tag, " err_short"},    err_short, 0);
        checkOutput({tag, " rd_addr"},      rd_addr, 0);
        checkOutput({tag, " rd_size"},      rd_size, 0);
    endtask

    // Beats are offered at the negedge; s_tready seen there holds through the next posedge.
    task automatic sendBeats(input int vidx, input vec_t v, input int count);
        int beat = 0;
        int cyc  = 0;
        bit gap;
        bit acc;
        while (beat < count && cyc < 300) begin
            gap      = v.gaps && ($urandom_range(0, 2) == 0);
            s_tvalid = !gap;
            s_tdata  = mk_data(vidx, beat);
            s_tlast  = (beat == v.tlast_at);
            acc      = s_tready && !gap;
            rd_done  = acc && v.rd_with_last && (beat == v.n_beats - 1);
            @(negedge kernel_clk);
            cyc++;
            if (acc) beat++;
        end
        s_tvalid = 1'b0;
        s_tlast  = 1'b0;
        rd_done  = 1'b0;
        checkOutput($sformatf("v%0d beats_accepted", vidx), DATA_W'(beat), DATA_W'(count));
        if (!v.rd_with_last && count == v.n_beats) begin
            rd_done = 1'b1;
            @(negedge kernel_clk);
            rd_done = 1'b0;
        end
    endtask

    task automatic runLoad(input int vidx, input vec_t v);
        int wr_base, done_base, rds_base, err_base, n_wr;
        @(negedge kernel_clk);
        wr_base   = wr_mask_q.size();
        done_base = ap_done_cnt;
        rds_base  = rd_start_cnt;
        err_base  = err_cnt;
        applyStimulus(v);
        if (v.poke_start) begin
            @(negedge kernel_clk);
            ctrl_instruction = mk_inst(1, 0, 300, 0, 0, 0);
            ctrl_addr_offset = 64'hDEAD_0000;
            ap_start         = 1'b1;
            @(negedge kernel_clk);
            ap_start = 1'b0;
        end
        sendBeats(vidx, v, v.n_beats);
        repeat (12) @(negedge kernel_clk);
        n_wr = wr_mask_q.size() - wr_base;
        checkOutput($sformatf("v%0d rd_addr", vidx), rd_addr, v.exp_rd_addr);
        checkOutput($sformatf("v%0d rd_size", vidx), rd_size, DATA_W'(v.byte_len));
        checkOutput($sformatf("v%0d rd_start_pulses", vidx), DATA_W'(rd_start_cnt - rds_base),
                    DATA_W'((v.word_cnt != 0) ? 1 : 0));
        checkOutput($sformatf("v%0d ap_done_pulses", vidx), DATA_W'(ap_done_cnt - done_base), 1);
        checkOutput($sformatf("v%0d err_short_pulses", vidx), DATA_W'(err_cnt - err_base),
                    DATA_W'(v.exp_short));
        checkOutput($sformatf("v%0d write_count", vidx), DATA_W'(n_wr), DATA_W'(v.exp_writes));
        checkOutput($sformatf("v%0d ap_ready_after", vidx), ap_ready, 1);
        for (int k = 0; k < v.exp_writes; k++) begin
            if (k < n_wr) begin
                checkOutput($sformatf("v%0d w%0d mask", vidx, k), wr_mask_q[wr_base + k],
                            DATA_W'(v.exp_mask[k]));
                checkOutput($sformatf("v%0d w%0d addr", vidx, k), wr_addr_q[wr_base + k],
                            DATA_W'(v.exp_addr[k]));
                checkOutput($sformatf("v%0d w%0d data", vidx, k), wr_data_q[wr_base + k],
                            mk_data(vidx, k));
            end
        end
    endtask

    initial begin
        int  done_base, rds_base, wr_base;
        bit  seen;

        kernel_rst       = 1'b1;
        ap_start         = 1'b0;
        ctrl_addr_offset = '0;
        ctrl_instruction = '0;
        rd_done          = 1'b0;
        s_tvalid         = 1'b0;
        s_tlast          = 1'b0;
        s_tdata          = '0;

        // mode, sel, buf_start, cnt, dram, len, offset, exp rd_addr, beats, tlast_at, gaps, rdlast, poke, writes, short
        tbl[0] = makeVec(1, 0, 10, 3, 'h100, 192, 64'h2000, 64'h2100, 3, 2, 0, 0, 0, 3, 0);
        tbl[0].exp_mask = '{15, 15, 15, 0, 0, 0, 0, 0};
        tbl[0].exp_addr = '{10, 11, 12, 0, 0, 0, 0, 0};
        tbl[1] = makeVec(2, 0, 0, 6, 'h80, 384, 64'h0, 64'h80, 6, 5, 1, 0, 0, 6, 0);
        tbl[1].exp_mask = '{1, 2, 4, 8, 1, 2, 0, 0};
        tbl[1].exp_addr = '{0, 0, 0, 0, 1, 1, 0, 0};
        tbl[2] = makeVec(0, 2, 510, 4, 'h40, 256, 64'h1000, 64'h1040, 4, 3, 0, 0, 0, 4, 0);
        tbl[2].exp_mask = '{4, 4, 4, 4, 0, 0, 0, 0};
        tbl[2].exp_addr = '{510, 511, 0, 1, 0, 0, 0, 0};
        tbl[3] = makeVec(3, 0, 5, 2, 'h10, 128, 64'h0, 64'h10, 2, 1, 0, 1, 0, 2, 0);
        tbl[3].exp_mask = '{15, 15, 0, 0, 0, 0, 0, 0};
        tbl[3].exp_addr = '{5, 6, 0, 0, 0, 0, 0, 0};
        tbl[4] = makeVec(1, 0, 40, 4, 'hFFFF, 256, 64'h10_0000_0000, 64'h10_0000_FFFF, 2, 1, 0, 0, 0, 2, 1);
        tbl[4].exp_mask = '{15, 15, 0, 0, 0, 0, 0, 0};
        tbl[4].exp_addr = '{40, 41, 0, 0, 0, 0, 0, 0};
        tbl[5] = makeVec(1, 0, 100, 4, 'h200, 256, 64'h0, 64'h200, 6, 5, 0, 0, 0, 4, 0);
        tbl[5].exp_mask = '{15, 15, 15, 15, 0, 0, 0, 0};
        tbl[5].exp_addr = '{100, 101, 102, 103, 0, 0, 0, 0};
        tbl[6] = makeVec(2, 0, 7, 5, 'h0, 320, 64'h4000, 64'h4000, 5, 4, 1, 0, 0, 5, 0);
        tbl[6].exp_mask = '{1, 2, 4, 8, 1, 0, 0, 0};
        tbl[6].exp_addr = '{7, 7, 7, 7, 8, 0, 0, 0};
        tbl[7] = makeVec(0, 5, 0, 2, 'h20, 128, 64'h8, 64'h28, 2, 1, 0, 0, 1, 2, 0);
        tbl[7].exp_mask = '{2, 2, 0, 0, 0, 0, 0, 0};
        tbl[7].exp_addr = '{0, 1, 0, 0, 0, 0, 0, 0};
        tbl[8] = makeVec(1, 0, 511, 2, 'h30, 128, 64'h0, 64'h30, 2, 1, 1, 1, 1, 2, 0);
        tbl[8].exp_mask = '{15, 15, 0, 0, 0, 0, 0, 0};
        tbl[8].exp_addr = '{511, 0, 0, 0, 0, 0, 0, 0};

        repeat (2) @(negedge kernel_clk);
        checkIdleOutputs("reset");
        kernel_rst = 1'b0;
        @(negedge kernel_clk);

        for (int i = 0; i < 9; i++) begin
            runLoad(i, tbl[i]);
        end

        // Zero-length load: no read request, no writes, ap_done within three cycles.
        done_base = ap_done_cnt;
        rds_base  = rd_start_cnt;
        wr_base   = wr_mask_q.size();
        applyStimulus(makeVec(1, 0, 50, 0, 'h10, 0, 64'h100, 64'h110, 0, 0, 0, 0, 0, 0, 0));
        seen = 1'b0;
        for (int k = 0; k < 3 && !seen; k++) begin
            if (ap_done) seen = 1'b1;
            else @(negedge kernel_clk);
        end
        checkOutput("zero_cnt ap_done_in_3", DATA_W'(seen), 1);
        repeat (6) @(negedge kernel_clk);
        checkOutput("zero_cnt rd_start_pulses", DATA_W'(rd_start_cnt - rds_base), 0);
        checkOutput("zero_cnt write_count", DATA_W'(wr_mask_q.size() - wr_base), 0);
        checkOutput("zero_cnt ap_done_pulses", DATA_W'(ap_done_cnt - done_base), 1);
        checkOutput("zero_cnt rd_addr", rd_addr, 64'h110);

        // Reset in the middle of a striped stream, then a clean load.
        applyStimulus(tbl[1]);
        sendBeats(1, tbl[1], 3);
        kernel_rst = 1'b1;
        #1;
        checkIdleOutputs("midreset");
        @(negedge kernel_clk);
        kernel_rst = 1'b0;
        @(negedge kernel_clk);
        runLoad(0, tbl[0]);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatch);
        $finish;
    end

endmodule
